conv_window_3x3: RTL and testbench

- Sits directly downstream of the pixel pre-processing stage (8-bit grey to normalised Q6.10).
- Consumes the stream of 16-bit Q6.10 pixels in raster order and builds, with two line buffers plus a 3x3 shift register, the 3x3 neighbourhood for the first convolution layer.
- Emits one packed 3x3 window per valid ("no padding") output position: (IMG_H-2)*(IMG_W-2) windows per frame.
- No backpressure; the upstream stage has none.

---
 rtl/conv_window_3x3_if.sv | 36 +++
 rtl/conv_window_3x3.sv | 154 +++++++++++++++
 tb/tb_conv_window_3x3.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/conv_window_3x3_if.sv
// Pixel-in / window-out bundle for conv_window_3x3.
// With CONV_WINDOW_POS_OUT_EN defined it also carries the window centre coordinates.
interface conv_window_3x3_if #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
);
    logic                  frame_sync;
    logic [DATA_W-1:0]     data_in;
    logic                  data_in_valid;
    logic [9*DATA_W-1:0]   window_out;
    logic                  window_valid;
    logic                  frame_done;
`ifdef CONV_WINDOW_POS_OUT_EN
    logic [$clog2(IMG_H)-1:0] win_row;
    logic [$clog2(IMG_W)-1:0] win_col;

    modport slave (
        input  frame_sync, data_in, data_in_valid,
        output window_out, window_valid, frame_done, win_row, win_col
    );
    modport master (
        output frame_sync, data_in, data_in_valid,
        input  window_out, window_valid, frame_done, win_row, win_col
    );
`else
    modport slave (
        input  frame_sync, data_in, data_in_valid,
        output window_out, window_valid, frame_done
    );
    modport master (
        output frame_sync, data_in, data_in_valid,
        input  window_out, window_valid, frame_done
    );
`endif
endinterface

// File: rtl/conv_window_3x3.sv
// 3x3 neighbourhood builder: two line buffers plus a 3x3 shift window, no-padding output.
// Optional macro CONV_WINDOW_POS_OUT_EN adds win_row/win_col centre outputs.
module conv_window_3x3 #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    conv_window_3x3_if.slave   bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [0:0] S_FILL   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [CW-1:0]        col_cnt_q, col_cnt_d, col_eff_s;
    logic [RW-1:0]        row_cnt_q, row_cnt_d, row_eff_s;
    logic [0:0]           state_q, state_d, state_eff_s;
    logic [9*DATA_W-1:0]  win_q, win_d;
    logic                 win_valid_q, win_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic [DATA_W-1:0]    lb0_q [IMG_W];
    logic [DATA_W-1:0]    lb1_q [IMG_W];
    logic [DATA_W-1:0]    lb0_rd_s, lb1_rd_s;
`ifdef CONV_WINDOW_POS_OUT_EN
    logic [RW-1:0]        win_row_q, win_row_d;
    logic [CW-1:0]        win_col_q, win_col_d;
`endif

    // frame_sync makes the current pixel (0,0) of a fresh frame
    always_comb begin
        if (bus.frame_sync) begin
            col_eff_s   = '0;
            row_eff_s   = '0;
            state_eff_s = S_FILL;
        end else begin
            col_eff_s   = col_cnt_q;
            row_eff_s   = row_cnt_q;
            state_eff_s = state_q;
        end
        lb0_rd_s = lb0_q[col_eff_s];
        lb1_rd_s = lb1_q[col_eff_s];
    end

    // Raster counters and fill/active state
    always_comb begin
        col_cnt_d = col_eff_s;
        row_cnt_d = row_eff_s;
        state_d   = state_eff_s;
        if (bus.data_in_valid) begin
            if (col_eff_s == CW'(IMG_W - 1)) begin
                col_cnt_d = '0;
                if (row_eff_s == RW'(IMG_H - 1)) begin
                    row_cnt_d = '0;
                    state_d   = S_FILL;
                end else begin
                    row_cnt_d = row_eff_s + RW'(1);
                    if (row_eff_s == RW'(1)) begin
                        state_d = S_ACTIVE;
                    end else begin
                        state_d = state_eff_s;
                    end
                end
            end else begin
                col_cnt_d = col_eff_s + CW'(1);
            end
        end else begin
            col_cnt_d = col_eff_s;
        end
    end

    // Window shift, valid and frame_done generation
    always_comb begin
        win_d        = win_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (bus.data_in_valid) begin
            win_d[DATA_W*0 +: DATA_W] = win_q[DATA_W*1 +: DATA_W];
            win_d[DATA_W*1 +: DATA_W] = win_q[DATA_W*2 +: DATA_W];
            win_d[DATA_W*2 +: DATA_W] = lb0_rd_s;
            win_d[DATA_W*3 +: DATA_W] = win_q[DATA_W*4 +: DATA_W];
            win_d[DATA_W*4 +: DATA_W] = win_q[DATA_W*5 +: DATA_W];
            win_d[DATA_W*5 +: DATA_W] = lb1_rd_s;
            win_d[DATA_W*6 +: DATA_W] = win_q[DATA_W*7 +: DATA_W];
            win_d[DATA_W*7 +: DATA_W] = win_q[DATA_W*8 +: DATA_W];
            win_d[DATA_W*8 +: DATA_W] = bus.data_in;
            case (state_eff_s)
                S_ACTIVE: win_valid_d = (col_eff_s >= CW'(2));
                default:  win_valid_d = 1'b0;
            endcase
            frame_done_d = win_valid_d && (row_eff_s == RW'(IMG_H - 1))
                           && (col_eff_s == CW'(IMG_W - 1));
        end else begin
            win_valid_d  = 1'b0;
        end
    end

`ifdef CONV_WINDOW_POS_OUT_EN
    // Centre of the triggering pixel's window, held between windows
    always_comb begin
        if (win_valid_d) begin
            win_row_d = row_eff_s - RW'(1);
            win_col_d = col_eff_s - CW'(1);
        end else begin
            win_row_d = win_row_q;
            win_col_d = win_col_q;
        end
    end
`endif

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_q    <= '0;
            row_cnt_q    <= '0;
            state_q      <= S_FILL;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef CONV_WINDOW_POS_OUT_EN
            win_row_q    <= '0;
            win_col_q    <= '0;
`endif
        end else begin
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            state_q      <= state_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
`ifdef CONV_WINDOW_POS_OUT_EN
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
`endif
        end
    end

    // Line buffers: read-before-write, row-1 migrates into the row-2 buffer
    always_ff @(posedge clk) begin
        if (bus.data_in_valid && !rst) begin
            lb0_q[col_eff_s] <= lb1_rd_s;
            lb1_q[col_eff_s] <= bus.data_in;
        end
    end

    assign bus.window_out   = win_q;
    assign bus.window_valid = win_valid_q;
    assign bus.frame_done   = frame_done_q;
`ifdef CONV_WINDOW_POS_OUT_EN
    assign bus.win_row      = win_row_q;
    assign bus.win_col      = win_col_q;
`endif
endmodule

// File: tb/tb_conv_window_3x3.sv
// Directed self-checking bench for conv_window_3x3: scenario table plus frame_sync and reset sequences.
module tb_conv_window_3x3;
    localparam int W  = 28;
    localparam int H  = 28;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_window_3x3_if #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) bus ();
    conv_window_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int win_cnt = 0;
    int done_cnt = 0;
    logic got_first;
    logic [9*DW-1:0] first_win;
    logic [9*DW-1:0] last_win;

    typedef struct {
        int gap_mode;
        int n_frames;
        int base_step;
        int exp_windows;
        int exp_dones;
    } scen_t;
    scen_t scen [3];

    function automatic logic [9*DW-1:0] model_win(input int base, input int r, input int c);
        logic [9*DW-1:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[DW*(3*i+j) +: DW] = DW'(base + (r - 2 + i) * W + (c - 2 + j));
        return w;
    endfunction

    task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check registered outputs just after the posedge
    task automatic step(input logic v, input logic [DW-1:0] px, input logic fs,
                        input int base, input int r, input int c);
        logic ev;
        logic ed;
        ev = v && (r >= 2) && (c >= 2);
        ed = ev && (r == H - 1) && (c == W - 1);
        @(negedge clk);
        bus.data_in_valid = v;
        bus.data_in       = px;
        bus.frame_sync    = fs;
        @(posedge clk);
        #1;
        chk_i("window_valid", int'(bus.window_valid), int'(ev));
        chk_i("frame_done", int'(bus.frame_done), int'(ed));
        if (ev) begin
            chk("window_out", bus.window_out, model_win(base, r, c));
`ifdef CONV_WINDOW_POS_OUT_EN
            chk_i("win_row", int'(bus.win_row), r - 1);
            chk_i("win_col", int'(bus.win_col), c - 1);
`endif
        end
        if (bus.window_valid) begin
            win_cnt++;
            last_win = bus.window_out;
            if (!got_first) begin
                first_win = bus.window_out;
                got_first = 1'b1;
            end
        end
        if (bus.frame_done) done_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, 0, 0, 0);
    endtask

    task automatic send_px(input int base, input int idx, input logic fs);
        step(1'b1, DW'(base + idx), fs, base, idx / W, idx % W);
    endtask

    task automatic run_pixels(input int base, input int gap_mode, input int first, input int last);
        for (int idx = first; idx <= last; idx++) begin
            send_px(base, idx, 1'b0);
            if (gap_mode == 1) begin
                idle(1);
                if ($urandom_range(0, 19) == 0) idle(int'($urandom_range(1, 5)));
            end
        end
    endtask

    task automatic reset_counts();
        win_cnt   = 0;
        done_cnt  = 0;
        got_first = 1'b0;
    endtask

    initial begin
        scen[0] = '{gap_mode: 0, n_frames: 1, base_step: 0,    exp_windows: 676,  exp_dones: 1};
        scen[1] = '{gap_mode: 1, n_frames: 1, base_step: 0,    exp_windows: 676,  exp_dones: 1};
        scen[2] = '{gap_mode: 0, n_frames: 3, base_step: 1000, exp_windows: 2028, exp_dones: 3};

        bus.data_in_valid = 1'b0;
        bus.data_in       = '0;
        bus.frame_sync    = 1'b0;
        rst               = 1'b1;
        got_first         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset window_out", bus.window_out, '0);
        chk_i("reset window_valid", int'(bus.window_valid), 0);
        chk_i("reset frame_done", int'(bus.frame_done), 0);
`ifdef CONV_WINDOW_POS_OUT_EN
        chk_i("reset win_row", int'(bus.win_row), 0);
        chk_i("reset win_col", int'(bus.win_col), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 3; s++) begin
            reset_counts();
            for (int f = 0; f < scen[s].n_frames; f++)
                run_pixels(f * scen[s].base_step, scen[s].gap_mode, 0, W * H - 1);
            idle(2);
            chk_i("window_count", win_cnt, scen[s].exp_windows);
            chk_i("frame_done_count", done_cnt, scen[s].exp_dones);
            if (s == 0) begin
                chk_i("first (0,0)", int'(first_win[DW*0 +: DW]), 0);
                chk_i("first (1,1)", int'(first_win[DW*4 +: DW]), 29);
                chk_i("first (2,2)", int'(first_win[DW*8 +: DW]), 58);
                chk_i("last (0,0)", int'(last_win[DW*0 +: DW]), 725);
                chk_i("last (2,2)", int'(last_win[DW*8 +: DW]), 783);
            end
        end

        // frame_sync together with the pixel at raster index 300
        reset_counts();
        run_pixels(0, 0, 0, 299);
        chk_i("windows before sync", win_cnt, 226);
        send_px(5000, 0, 1'b1);
        run_pixels(5000, 0, 1, 57);
        chk_i("no window after sync", win_cnt, 226);
        run_pixels(5000, 0, 58, W * H - 1);
        idle(2);
        chk_i("sync window_count", win_cnt, 226 + 676);
        chk_i("sync frame_done_count", done_cnt, 1);

        // rst held for three cycles in the middle of row 10
        reset_counts();
        run_pixels(0, 0, 0, 10 * W + 5);
        repeat (3) begin
            @(negedge clk);
            rst = 1'b1;
            bus.data_in_valid = 1'b0;
            bus.frame_sync    = 1'b0;
            @(posedge clk);
            #1;
            chk("rst window_out", bus.window_out, '0);
            chk_i("rst window_valid", int'(bus.window_valid), 0);
            chk_i("rst frame_done", int'(bus.frame_done), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        reset_counts();
        run_pixels(3000, 0, 0, W * H - 1);
        idle(2);
        chk_i("post-rst window_count", win_cnt, 676);
        chk_i("post-rst frame_done_count", done_cnt, 1);
        chk_i("post-rst first (0,0)", int'(first_win[DW*0 +: DW]), 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
